// File: rtl/led_seq_pkg.sv
// Shared types and default sizing for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {LED_OFF, LED_ON, LED_BLINK, LED_BURST} led_mode_e;

    localparam int unsigned DEF_NUM_LEDS = 4;
    localparam int unsigned DEF_TICK_DIV = 100_000;
    localparam int unsigned DEF_PER_W    = 16;
    localparam int unsigned DEF_CNT_W    = 8;

endpackage

// File: rtl/led_seq_channel.sv
// One LED channel: mode, tick counter, burst pulse counter and registered LED drive.
module led_seq_channel
    import led_seq_pkg::*;
#(
    parameter int unsigned PER_W = DEF_PER_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_load,
    input  led_mode_e        i_mode,
    input  logic [PER_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_led,
    output logic             o_busy,
    output logic             o_done
);

    led_mode_e        mode_q, mode_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             led_q, led_d;
    logic             done_q, done_d;

    always_comb begin
        mode_d = mode_q;
        per_d  = per_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        led_d  = led_q;
        done_d = 1'b0;
        // A load takes priority over a coincident tick.
        if (i_load) begin
            cnt_d  = '0;
            per_d  = (i_period == '0) ? PER_W'(1) : i_period;
            mode_d = i_mode;
            rem_d  = i_count;
            unique case (i_mode)
                LED_OFF:           led_d = 1'b0;
                LED_ON, LED_BLINK: led_d = 1'b1;
                LED_BURST: begin
                    if (i_count == '0) begin
                        mode_d = LED_OFF;
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        led_d = 1'b1;
                    end
                end
            endcase
        end else if (i_tick && (mode_q == LED_BLINK || mode_q == LED_BURST)) begin
            if (cnt_q == per_q - PER_W'(1)) begin
                cnt_d = '0;
                led_d = ~led_q;
                // Falling edge of a burst pulse consumes one pulse.
                if (mode_q == LED_BURST && led_q) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        mode_d = LED_OFF;
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q <= LED_OFF;
            per_q  <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            per_q  <= per_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    assign o_led  = led_q;
    assign o_busy = (mode_q == LED_BLINK) || (mode_q == LED_BURST);
    assign o_done = done_q;

endmodule

// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer: shared prescaler, config decode and per-channel pattern engines.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned PER_W    = DEF_PER_W,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    localparam int unsigned CH_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [1:0]          i_cfg_mode,
    input  logic [PER_W-1:0]    i_cfg_period,
    input  logic [CNT_W-1:0]    i_cfg_count,
    output logic [NUM_LEDS-1:0] o_led,
    output logic [NUM_LEDS-1:0] o_busy,
    output logic [NUM_LEDS-1:0] o_done
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] presc_q;
    logic             tick;
    logic             ready_q;
    logic             accept;

    assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

    // Prescaler free-runs; config writes never disturb it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            ready_q <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PRE_W'(1);
            ready_q <= 1'b1;
        end
    end

    assign o_cfg_ready = ready_q;
    assign accept      = i_cfg_valid & ready_q;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        logic load;
        // Out-of-range channel numbers match nothing and are dropped.
        assign load = accept && (i_cfg_ch == CH_W'(g));

        led_seq_channel #(
            .PER_W (PER_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_tick   (tick),
            .i_load   (load),
            .i_mode   (led_mode_e'(i_cfg_mode)),
            .i_period (i_cfg_period),
            .i_count  (i_cfg_count),
            .o_led    (o_led[g]),
            .o_busy   (o_busy[g]),
            .o_done   (o_done[g])
        );
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_led_sequencer;
    import led_seq_pkg::*;

    logic       tb_clk     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [1:0] cfg_ch     = '0;
    logic [1:0] cfg_mode   = '0;
    logic [7:0] cfg_period = '0;
    logic [3:0] cfg_count  = '0;
    logic       cfg_ready, cfg_ready3;
    logic [3:0] led, busy, done;
    logic [2:0] led3, busy3, done3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 tb_clk = ~tb_clk;

    led_sequencer #(.NUM_LEDS(4), .TICK_DIV(4), .PER_W(8), .CNT_W(4)) dut (
        .i_clk(tb_clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_period(cfg_period),
        .i_cfg_count(cfg_count), .o_led(led), .o_busy(busy), .o_done(done)
    );

    led_sequencer #(.NUM_LEDS(3), .TICK_DIV(4), .PER_W(8), .CNT_W(4)) dut3 (
        .i_clk(tb_clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready3),
        .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_period(cfg_period),
        .i_cfg_count(cfg_count), .o_led(led3), .o_busy(busy3), .o_done(done3)
    );

    typedef struct {
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] per;
        logic [3:0] cnt;
        int         dly;
        logic [3:0] led;
        logic [3:0] busy;
        logic [3:0] done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
        cyc++;
    endtask

    task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] per,
                         input logic [3:0] cnt);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_count  = cnt;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic clear_all();
        for (int c = 0; c < 4; c++) write(2'(c), LED_OFF, 8'd1, 4'd0);
    endtask

    // Ticks land on edges where cyc%4==0; aligning to 1 puts the accept edge at cyc%4==2.
    task automatic align(input int k);
        while (cyc % 4 != k) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_led", 32'(led), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'({cfg_ready, cfg_ready3}), 0);
        rst_n = 1'b1;
        cyc = 0;
        check("ready_before_edge", 32'(cfg_ready), 0);
        step();
        check("ready_after_edge", 32'(cfg_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e0;
        int   prev;
        bit   bad;
        bit   done_seen;
        int   tog[$];

        //               ch mode       per   cnt  dly led      busy     done
        vecs.push_back('{2'd0, LED_OFF,   8'd0, 4'd0, 0,  4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd1, LED_ON,    8'd5, 4'd0, 0,  4'b0010, 4'b0000, 4'b0000});
        vecs.push_back('{2'd1, LED_ON,    8'd5, 4'd0, 20, 4'b0010, 4'b0000, 4'b0000});
        vecs.push_back('{2'd0, LED_BLINK, 8'd3, 4'd0, 0,  4'b0001, 4'b0001, 4'b0000});
        vecs.push_back('{2'd0, LED_BLINK, 8'd3, 4'd0, 9,  4'b0001, 4'b0001, 4'b0000});
        vecs.push_back('{2'd0, LED_BLINK, 8'd3, 4'd0, 10, 4'b0000, 4'b0001, 4'b0000});
        vecs.push_back('{2'd0, LED_BLINK, 8'd3, 4'd0, 21, 4'b0000, 4'b0001, 4'b0000});
        vecs.push_back('{2'd0, LED_BLINK, 8'd3, 4'd0, 22, 4'b0001, 4'b0001, 4'b0000});
        vecs.push_back('{2'd2, LED_BLINK, 8'd1, 4'd0, 1,  4'b0100, 4'b0100, 4'b0000});
        vecs.push_back('{2'd2, LED_BLINK, 8'd1, 4'd0, 2,  4'b0000, 4'b0100, 4'b0000});
        vecs.push_back('{2'd2, LED_BLINK, 8'd1, 4'd0, 6,  4'b0100, 4'b0100, 4'b0000});
        vecs.push_back('{2'd3, LED_BLINK, 8'd0, 4'd0, 2,  4'b0000, 4'b1000, 4'b0000});
        vecs.push_back('{2'd3, LED_BLINK, 8'd0, 4'd0, 6,  4'b1000, 4'b1000, 4'b0000});
        vecs.push_back('{2'd1, LED_BURST, 8'd1, 4'd2, 0,  4'b0010, 4'b0010, 4'b0000});
        vecs.push_back('{2'd1, LED_BURST, 8'd1, 4'd2, 2,  4'b0000, 4'b0010, 4'b0000});
        vecs.push_back('{2'd1, LED_BURST, 8'd1, 4'd2, 6,  4'b0010, 4'b0010, 4'b0000});
        vecs.push_back('{2'd1, LED_BURST, 8'd1, 4'd2, 10, 4'b0000, 4'b0000, 4'b0010});
        vecs.push_back('{2'd1, LED_BURST, 8'd1, 4'd2, 11, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd1, LED_BURST, 8'd1, 4'd2, 50, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd2, LED_BURST, 8'd3, 4'd0, 0,  4'b0000, 4'b0000, 4'b0100});
        vecs.push_back('{2'd2, LED_BURST, 8'd3, 4'd0, 1,  4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{2'd3, LED_BURST, 8'd2, 4'd1, 5,  4'b1000, 4'b1000, 4'b0000});
        vecs.push_back('{2'd3, LED_BURST, 8'd2, 4'd1, 6,  4'b0000, 4'b0000, 4'b1000});

        // Reset, then async reset while blinking.
        do_reset();
        write(2'd0, LED_BLINK, 8'd1, 4'd0);
        check("blink_before_reset", 32'(led), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 0);
        check("async_rst_busy", 32'(busy), 0);
        do_reset();

        // Vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            clear_all();
            align(1);
            write(vecs[i].ch, vecs[i].mode, vecs[i].per, vecs[i].cnt);
            repeat (vecs[i].dly) step();
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
        end

        // BLINK period 3: steady phases of 12 clocks over 5 full periods.
        clear_all();
        align(1);
        write(2'd0, LED_BLINK, 8'd3, 4'd0);
        e0   = cyc;
        prev = int'(led[0]);
        bad  = 1'b0;
        for (int k = 0; k < 200 && tog.size() < 11; k++) begin
            step();
            if (led[3:1] != 3'b000 || busy != 4'b0001) bad = 1'b1;
            if (int'(led[0]) != prev) begin
                tog.push_back(cyc);
                prev = int'(led[0]);
            end
        end
        check("blink_toggles", 32'(tog.size()), 11);
        if (tog.size() > 0) check("blink_first_phase", 32'(tog[0] - e0), 10);
        for (int i = 1; i < 11; i++) begin
            if (i < tog.size()) check($sformatf("blink_phase%0d", i), 32'(tog[i] - tog[i-1]), 12);
        end
        check("blink_other_channels", 32'(bad), 0);

        // Config on a tick edge restarts ch2's counter; ch0 keeps its schedule.
        clear_all();
        align(1);
        write(2'd0, LED_BLINK, 8'd2, 4'd0);
        repeat (5) step();
        write(2'd2, LED_BLINK, 8'd2, 4'd0);
        check("tickload_e6", 32'(led), 32'h4);
        repeat (4) step();
        check("tickload_e10", 32'(led), 32'h4);
        repeat (3) step();
        check("tickload_e13", 32'(led), 32'h4);
        step();
        check("tickload_e14", 32'(led), 32'h1);
        check("tickload_busy", 32'(busy), 32'h5);

        // Out-of-range channel on a 3-channel instance.
        clear_all();
        write(2'd3, LED_ON, 8'd1, 4'd0);
        check("oor_led4", 32'(led), 32'h8);
        check("oor_led3", 32'({led3, busy3}), 0);
        write(2'd3, LED_BURST, 8'd1, 4'd0);
        check("oor_done4", 32'(done), 32'h8);
        check("oor_done3", 32'(done3), 0);
        write(2'd2, LED_ON, 8'd1, 4'd0);
        check("inrange_led3", 32'(led3), 32'h4);

        // Aborting a running burst raises no done.
        clear_all();
        write(2'd1, LED_BURST, 8'd1, 4'd3);
        repeat (3) step();
        check("abort_busy_before", 32'(busy), 32'h2);
        write(2'd1, LED_OFF, 8'd1, 4'd0);
        done_seen = done[1];
        for (int k = 0; k < 20; k++) begin
            step();
            done_seen |= done[1];
        end
        check("abort_no_done", 32'(done_seen), 0);
        check("abort_led", 32'(led), 0);
        check("abort_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
